ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Fetch-side initiator for the combinational instruction memory. It owns the program counter and drives pc_addr every cycle. It captures the returned instruction word or fetch exception and buffers the results in a small FIFO for decode, using a valid/ready handshake. Branch and trap redirects from downstream flush the buffer and restart fetch at a new PC.

Parameters:
RESET_PC, 64'h0000_0000_0000_0000, PC loaded on reset.
FIFO_DEPTH, 2, fetch buffer entries; power of 2, minimum 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-low reset (asserted when 0).
pc_addr  output  64  fetch address to instruction memory; equals the internal PC register.
instruction  input  32  instruction word returned combinationally for pc_addr.
exc_en  input  1  fetch exception flag from instruction memory.
exc_code  input  4  fetch exception cause.
exc_val  input  64  fetch exception value (faulting PC).
redirect_en  input  1  flush the buffer and restart fetch.
redirect_pc  input  64  new fetch PC.
if_valid  output  1  head entry valid for decode.
if_ready  input  1  decode accepts the head entry.
if_pc  output  64  PC of the head entry.
if_instr  output  32  instruction of the head entry; 32'h00000013 when the entry carries an exception.
if_exc_en  output  1  head entry carries an exception.
if_exc_code  output  4  cause for the head entry.
if_exc_val  output  64  tval for the head entry.

Behaviour:
- Reset (rst==0 at a clock edge):
  - pc <= RESET_PC; FIFO empty; state <= RUN.
  - if_valid=0; if_pc, if_instr, if_exc_* all zero.
- States:
  - RUN: fetching.
  - FAULT: an exception entry has been pushed; fetch is halted.
- pop = if_valid & if_ready.
- push (in RUN) = not redirect_en, and (count < FIFO_DEPTH or pop).
  - A full FIFO with a simultaneous pop accepts a push in the same cycle.
- On push:
  - Entry = {pc, instruction, exc_en, exc_code, exc_val}.
  - If exc_en==1: instr stored as NOP; state <= FAULT; pc holds.
  - Else: pc <= pc + 4, wrapping modulo 2^64.
- Latency: an entry pushed at edge N is visible on if_* after edge N (one cycle from pc_addr to if_valid). The FIFO head is registered; if_* outputs are taken directly from the head entry.
- Exception sampling: the imem exception flags are sampled exactly once per pushed PC. Deasserted exc_en while holding in FAULT is ignored.
- FAULT: no push. Entries already in the FIFO drain normally. The unit stays in FAULT until redirect_en.
- Redirect (highest priority, any state):
  - FIFO cleared, including any entry being popped this cycle; if_valid=0 next cycle.
  - No push this cycle.
  - pc <= redirect_pc; state <= RUN.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - On the next edge, push a synthetic entry instead of fetching: pc=redirect_pc, exc_en=1, exc_code=4'd0, exc_val=redirect_pc.
  - State <= FAULT.
  - Held in a 1-bit misalign flag set with the redirect.
- Reset mid-operation: reset overrides redirect and handshake; all in-flight entries are discarded.
- Stall: if_ready=0 with a full FIFO means pc and pc_addr hold stable; no entry is lost or duplicated.

Optional Feature:
IFETCH_PERF_EN:
- Defined: adds output ports perf_fetched (64, count of pushes) and perf_stall (64, cycles in RUN with no push and no redirect).
  - Both counters reset to 0 and saturate at all-ones.
  - A redirect does not increment either counter.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - NOP_INSTR = 32'h00000013.
  - Exception cause constants: EXC_INSTR_MISALIGNED=4'd0, EXC_INSTR_ACCESS_FAULT=4'd1.
  - The fetch entry struct/typedef {pc, instr, exc_en, exc_code, exc_val}.
  - State encoding RUN/FAULT.
- One natural sub-module: ifetch_fifo, a synchronous FIFO with flush input, simultaneous push/pop when full, and registered head output.

Test Plan:
1. Sequential fetch: reset with RESET_PC=0, if_ready=1, imem returns words 0x11,0x22,0x33 at PCs 0,4,8 -> if_valid from cycle 1; if_pc/if_instr = 0/0x11, 4/0x22, 8/0x33 on consecutive cycles.
2. Backpressure: if_ready=0 for 5 cycles after 2 pushes -> pc_addr holds at 0x8, if_pc stays 0x0; release -> 0x0, 0x4, 0x8 delivered in order with no gaps or duplicates.
3. Access fault: imem asserts exc_en=1, exc_code=1, exc_val=0x2000 at pc 0x2000 -> entry has if_instr=0x13, if_exc_en=1, code 1, val 0x2000; pc_addr frozen at 0x2000 until redirect.
4. Redirect while full: FIFO full and if_ready=1, redirect_en with redirect_pc=0x100 -> next cycle if_valid=0, pc_addr=0x100; following cycle if_pc=0x100.
5. Misaligned redirect: redirect_pc=0x102 -> one entry with exc_code=0, exc_val=0x102; unit enters FAULT, no further pushes.
6. Reset mid-stream: drive rst=0 while 2 entries are buffered -> next cycle if_valid=0, pc_addr=RESET_PC; if IFETCH_PERF_EN is defined, both counters read 0.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   NOP_INSTR        : instruction word reported for entries that carry an exception
//   EXC_INSTR_*      : fetch exception causes
//   fetch_entry_t    : one fetch buffer entry {pc, instr, exc_en, exc_code, exc_val}
//   state_e          : fetch state (RUN / FAULT)
package ifetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR              = 32'h0000_0013;
  localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
  localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Fetch buffer: synchronous FIFO of fetch entries.
//   clk, rst (sync, active low)
//   push/push_data : write an entry (caller guarantees room, or a pop in the same cycle)
//   pop            : drop the head entry
//   flush          : empty the buffer; overrides push and pop
//   head/valid     : head entry taken straight from the storage flops
//   full           : all DEPTH entries occupied
module ifetch_fifo
  import ifetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         valid,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      // Full + pop + push: wr_q == rd_q, so the new entry lands in the slot
      // being vacated by the pop.
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + AW'(1);
      end
      if (pop) rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign valid = (cnt_q != '0);
  assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the PC, drives the combinational instruction
// memory, buffers fetched words / fetch exceptions for decode (valid/ready),
// and restarts on downstream redirects.
//   clk, rst (sync, active low)
//   pc_addr -> instruction, exc_en, exc_code, exc_val : imem interface
//   redirect_en, redirect_pc : flush and restart fetch
//   if_valid/if_ready, if_pc, if_instr, if_exc_* : decode interface
// Optional: define IFETCH_PERF_EN to add perf_fetched / perf_stall counters.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] pc_addr,
  input  logic [31:0] instruction,
  input  logic        exc_en,
  input  logic [3:0]  exc_code,
  input  logic [63:0] exc_val,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_exc_en,
  output logic [3:0]  if_exc_code,
  output logic [63:0] if_exc_val
`ifdef IFETCH_PERF_EN
  ,
  output logic [63:0] perf_fetched,
  output logic [63:0] perf_stall
`endif
);

  logic [63:0]  pc_q, pc_d;
  state_e       state_q, state_d;
  logic         misalign_q, misalign_d;
  logic         push, pop, flush, full;
  fetch_entry_t entry, head;

  assign pop = if_valid & if_ready;

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    misalign_d = misalign_q;
    push       = 1'b0;
    flush      = 1'b0;
    entry      = '{pc: pc_q, instr: instruction, exc_en: exc_en,
                   exc_code: exc_code, exc_val: exc_val};
    if (redirect_en) begin
      flush      = 1'b1;
      pc_d       = redirect_pc;
      state_d    = RUN;
      misalign_d = |redirect_pc[1:0];
    end else if (state_q == RUN && (!full || pop)) begin
      push = 1'b1;
      if (misalign_q) begin
        // Pending misaligned redirect: report it instead of fetching.
        entry      = '{pc: pc_q, instr: NOP_INSTR, exc_en: 1'b1,
                       exc_code: EXC_INSTR_MISALIGNED, exc_val: pc_q};
        state_d    = FAULT;
        misalign_d = 1'b0;
      end else if (exc_en) begin
        entry.instr = NOP_INSTR;
        state_d     = FAULT;
      end else begin
        pc_d = pc_q + 64'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      state_q    <= RUN;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      misalign_q <= misalign_d;
    end
  end

  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (entry),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .valid     (if_valid),
    .full      (full)
  );

  assign pc_addr     = pc_q;
  assign if_pc       = head.pc;
  assign if_instr    = head.instr;
  assign if_exc_en   = head.exc_en;
  assign if_exc_code = head.exc_code;
  assign if_exc_val  = head.exc_val;

`ifdef IFETCH_PERF_EN
  logic [63:0] perf_fetched_q, perf_fetched_d;
  logic [63:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (push && !(&perf_fetched_q)) perf_fetched_d = perf_fetched_q + 64'd1;
    if (state_q == RUN && !push && !redirect_en && !(&perf_stall_q))
      perf_stall_d = perf_stall_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_addr;
  logic [31:0] instruction;
  logic        exc_en;
  logic [3:0]  exc_code;
  logic [63:0] exc_val;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_exc_en;
  logic [3:0]  if_exc_code;
  logic [63:0] if_exc_val;
`ifdef IFETCH_PERF_EN
  logic [63:0] perf_fetched, perf_stall;
`endif

  // Memory model configuration (only changed right before a stream reload)
  logic [63:0] fault_pc;
  logic        rand_faults;

  fetch_entry_t exp_q[$];
  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .instruction(instruction),
    .exc_en(exc_en), .exc_code(exc_code), .exc_val(exc_val),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .if_exc_en(if_exc_en), .if_exc_code(if_exc_code), .if_exc_val(if_exc_val)
`ifdef IFETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  function automatic logic [31:0] imem_word(input logic [63:0] p);
    if (p < 64'd12) return 32'((p >> 2) + 64'd1) * 32'h11;
    return (p[31:0] * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic is_fault(input logic [63:0] p, input logic [63:0] fpc,
                                    input logic rnd);
    return (p == fpc) || (rnd && ((p >> 2) % 64'd23 == 64'd22));
  endfunction

  // Combinational instruction memory
  always_comb begin
    instruction = imem_word(pc_addr);
    exc_en      = is_fault(pc_addr, fault_pc, rand_faults);
    exc_code    = exc_en ? EXC_INSTR_ACCESS_FAULT : 4'd0;
    exc_val     = exc_en ? pc_addr : 64'd0;
  end

  // Reference: after a restart at `start`, decode must see the sequential
  // program stream up to and including the first faulting fetch, or just a
  // misaligned-fetch entry when start is misaligned.
  task automatic load_stream(input logic [63:0] start);
    fetch_entry_t e;
    logic [63:0]  p;
    exp_q.delete();
    if (start[1:0] != 2'b00) begin
      e = '{pc: start, instr: NOP_INSTR, exc_en: 1'b1, exc_code: 4'd0, exc_val: start};
      exp_q.push_back(e);
      return;
    end
    p = start;
    for (int i = 0; i < 1024; i++) begin
      if (is_fault(p, fault_pc, rand_faults)) begin
        e = '{pc: p, instr: NOP_INSTR, exc_en: 1'b1, exc_code: 4'd1, exc_val: p};
        exp_q.push_back(e);
        return;
      end
      e = '{pc: p, instr: imem_word(p), exc_en: 1'b0, exc_code: 4'd0, exc_val: 64'd0};
      exp_q.push_back(e);
      p = p + 64'd4;
    end
  endtask

  // Monitor: every accepted entry is compared against the scoreboard head.
  // Handshakes in redirect or reset cycles are discarded by the design.
  always @(negedge clk) begin
    if (rst && !redirect_en && if_valid && if_ready) begin
      n_tot++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_underflow: got pc=%h with no entry expected", if_pc);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        if (if_pc == e.pc && if_instr == e.instr && if_exc_en == e.exc_en &&
            if_exc_code == e.exc_code && if_exc_val == e.exc_val)
          n_pass++;
        else
          $display("FAIL entry: got pc=%h instr=%h exc=%b code=%h val=%h, want pc=%h instr=%h exc=%b code=%h val=%h",
                   if_pc, if_instr, if_exc_en, if_exc_code, if_exc_val,
                   e.pc, e.instr, e.exc_en, e.exc_code, e.exc_val);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    cyc(1);
    rst = 1'b1;
    load_stream(RESET_PC);
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    redirect_en = 1'b1;
    redirect_pc = pc;
    load_stream(pc);
    cyc(1);
    redirect_en = 1'b0;
  endtask

  initial begin
    logic [63:0] rpc;
    rst         = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 64'd0;
    if_ready    = 1'b1;
    fault_pc    = 64'hFFFF_FFFF_0000_0000;
    rand_faults = 1'b0;
    cyc(1);

    // 1. Reset state and sequential fetch
    do_reset();
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_pc_addr", pc_addr, RESET_PC);
    chk("rst_if_pc", if_pc, 64'd0);
    chk("rst_if_instr", 64'(if_instr), 64'd0);
    chk("rst_exc", {if_exc_val[62:0], if_exc_en} | 64'(if_exc_code), 64'd0);
`ifdef IFETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 64'd0);
    chk("rst_perf_stall", perf_stall, 64'd0);
`endif
    cyc(1);
    chk("seq_first_valid", 64'(if_valid), 64'd1);
    chk("seq_first_instr", 64'(if_instr), 64'h11);
    cyc(1);
    chk("seq_second_pc", if_pc, 64'h4);
    cyc(3);

    // 2. Backpressure
    if_ready = 1'b0;
    do_reset();
    cyc(6);
    chk("stall_pc_addr", pc_addr, 64'h8);
    chk("stall_if_pc", if_pc, 64'h0);
    if_ready = 1'b1;
    cyc(4);

    // 3. Access fault
    fault_pc = 64'h2000;
    do_redirect(64'h1FF8);
    cyc(8);
    chk("fault_pc_frozen", pc_addr, 64'h2000);
    chk("fault_drained", 64'(exp_q.size()), 64'd0);
    chk("fault_no_valid", 64'(if_valid), 64'd0);

    // 4. Redirect while full with a pop in the same cycle
    if_ready = 1'b0;
    do_redirect(64'h40);
    cyc(3);
    if_ready = 1'b1;
    do_redirect(64'h100);
    chk("redir_valid_low", 64'(if_valid), 64'd0);
    chk("redir_pc_addr", pc_addr, 64'h100);
    cyc(1);
    chk("redir_valid", 64'(if_valid), 64'd1);
    chk("redir_if_pc", if_pc, 64'h100);
    cyc(3);

    // 5. Misaligned redirect
    do_redirect(64'h102);
    chk("mis_valid_low", 64'(if_valid), 64'd0);
    chk("mis_pc_addr", pc_addr, 64'h102);
    cyc(1);
    chk("mis_code", 64'(if_exc_code), 64'd0);
    chk("mis_val", if_exc_val, 64'h102);
    cyc(5);
    chk("mis_halted", pc_addr, 64'h102);
    chk("mis_single", 64'(exp_q.size()), 64'd0);

    // 6. Reset mid-stream
    if_ready = 1'b0;
    do_redirect(64'h300);
    cyc(3);
    do_reset();
    chk("midrst_valid", 64'(if_valid), 64'd0);
    chk("midrst_pc_addr", pc_addr, RESET_PC);
`ifdef IFETCH_PERF_EN
    chk("midrst_perf_fetched", perf_fetched, 64'd0);
    chk("midrst_perf_stall", perf_stall, 64'd0);
`endif

    // Random traffic: backpressure, faults, redirects (incl. 64-bit wrap), resets
    rand_faults = 1'b1;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 24) == 0) begin
        if ($urandom_range(0, 7) == 0)
          rpc = 64'hFFFF_FFFF_FFFF_FF00 | (64'($urandom_range(0, 255)) & ~64'd3);
        else begin
          rpc = 64'($urandom_range(0, 16383));
          if ($urandom_range(0, 5) != 0) rpc[1:0] = 2'b00;
        end
        do_redirect(rpc);
      end else begin
        cyc(1);
      end
    end
    if_ready = 1'b1;
    cyc(4);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
